// File: rtl/sr04_scan_scheduler.sv
// sr04_scan_scheduler: round-robin scan scheduler that shares one SR04
// measurement controller across NUM_SENSORS ultrasonic sensors.
// Each slot issues a one-clk start pulse, waits for meas_done or a timeout,
// holds off until the minimum start-to-start period has elapsed, and publishes
// a tagged distance result (all ones on timeout).
// Optional build macro: SR04_SCAN_BANK_EN adds a per-sensor result bank read
// through rd_idx/rd_dist; without it rd_dist is tied to 0.
module sr04_scan_scheduler #(
    parameter int NUM_SENSORS = 4,
    parameter int PERIOD_US   = 60000,
    parameter int TIMEOUT_US  = 30000,
    parameter int DIST_W      = 12,
    localparam int SEL_W      = $clog2(NUM_SENSORS),
    localparam int CNT_W      = $clog2(PERIOD_US + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_1MHz,
    input  logic              enable,
    input  logic              single,
    input  logic              meas_done,
    input  logic [DIST_W-1:0] meas_dist,
    output logic              meas_start,
    output logic              meas_abort,
    output logic [SEL_W-1:0]  sensor_sel,
    output logic              busy,
    output logic              result_valid,
    output logic [SEL_W-1:0]  result_idx,
    output logic [DIST_W-1:0] result_dist,
    output logic              result_timeout,
    input  logic [SEL_W-1:0]  rd_idx,
    output logic [DIST_W-1:0] rd_dist
);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD_US);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_US);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_SENSORS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  elapsed_q, elapsed_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              sweepFlag_q, sweepFlag_d;
    logic [SEL_W-1:0]  sweepStart_q, sweepStart_d;

    logic              measStart_q, measStart_d;
    logic              measAbort_q, measAbort_d;
    logic              busy_q, busy_d;
    logic              resultValid_q, resultValid_d;
    logic [SEL_W-1:0]  resultIdx_q, resultIdx_d;
    logic [DIST_W-1:0] resultDist_q, resultDist_d;
    logic              resultTimeout_q, resultTimeout_d;

    logic [CNT_W-1:0]  elapsedInc;
    logic [SEL_W-1:0]  selNext;
    logic              timeoutHit;
    logic              slotEnd;

    // Elapsed time saturates at the period so a long GAP can never wrap it
    assign elapsedInc = (tick_1MHz && (elapsed_q != PERIOD_C)) ? elapsed_q + CNT_W'(1) : elapsed_q;
    assign selNext    = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
    assign timeoutHit = (elapsed_q == TIMEOUT_C);
    assign slotEnd    = (elapsed_q >= PERIOD_C);

    // State, slot timing and every registered output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            elapsed_q       <= '0;
            sel_q           <= '0;
            sweepFlag_q     <= 1'b0;
            sweepStart_q    <= '0;
            measStart_q     <= 1'b0;
            measAbort_q     <= 1'b0;
            busy_q          <= 1'b0;
            resultValid_q   <= 1'b0;
            resultIdx_q     <= '0;
            resultDist_q    <= '0;
            resultTimeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            elapsed_q       <= elapsed_d;
            sel_q           <= sel_d;
            sweepFlag_q     <= sweepFlag_d;
            sweepStart_q    <= sweepStart_d;
            measStart_q     <= measStart_d;
            measAbort_q     <= measAbort_d;
            busy_q          <= busy_d;
            resultValid_q   <= resultValid_d;
            resultIdx_q     <= resultIdx_d;
            resultDist_q    <= resultDist_d;
            resultTimeout_q <= resultTimeout_d;
        end
    end

    // Slot sequencing: start, wait for done/timeout, hold off until the period ends
    always_comb begin
        state_d      = state_q;
        elapsed_d    = elapsed_q;
        sel_d        = sel_q;
        sweepFlag_d  = sweepFlag_q;
        sweepStart_d = sweepStart_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = START;
                end else if (single) begin
                    state_d      = START;
                    sweepFlag_d  = 1'b1;
                    sweepStart_d = sel_q;
                end
            end
            START: begin
                elapsed_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                elapsed_d = elapsedInc;
                if (meas_done || timeoutHit) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                elapsed_d = elapsedInc;
                if (slotEnd) begin
                    sel_d = selNext;
                    if (enable) begin
                        state_d = START;
                    end else if (sweepFlag_q && (selNext != sweepStart_q)) begin
                        state_d = START;
                    end else begin
                        sweepFlag_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output pulses and result fields; done beats a simultaneous timeout
    always_comb begin
        measStart_d     = (state_d == START);
        busy_d          = (state_d != IDLE);
        measAbort_d     = 1'b0;
        resultValid_d   = 1'b0;
        resultIdx_d     = resultIdx_q;
        resultDist_d    = resultDist_q;
        resultTimeout_d = resultTimeout_q;
        if (state_q == WAIT) begin
            if (meas_done) begin
                resultValid_d   = 1'b1;
                resultIdx_d     = sel_q;
                resultDist_d    = meas_dist;
                resultTimeout_d = 1'b0;
            end else if (timeoutHit) begin
                measAbort_d     = 1'b1;
                resultValid_d   = 1'b1;
                resultIdx_d     = sel_q;
                resultDist_d    = '1;
                resultTimeout_d = 1'b1;
            end
        end
    end

    assign meas_start     = measStart_q;
    assign meas_abort     = measAbort_q;
    assign sensor_sel     = sel_q;
    assign busy           = busy_q;
    assign result_valid   = resultValid_q;
    assign result_idx     = resultIdx_q;
    assign result_dist    = resultDist_q;
    assign result_timeout = resultTimeout_q;

`ifdef SR04_SCAN_BANK_EN
    // Bank is sized to the full index range so out-of-range reads hit entries
    // that are never written and therefore always read back as 0.
    localparam int BANK_N = 1 << SEL_W;

    logic [DIST_W-1:0] bank_q [BANK_N];

    // Bank entry of the reporting sensor follows every published result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BANK_N; i++) begin
                bank_q[i] <= '0;
            end
        end else if (resultValid_d) begin
            bank_q[sel_q] <= resultDist_d;
        end
    end

    assign rd_dist = bank_q[rd_idx];
`else
    logic unusedRdIdx;

    assign unusedRdIdx = ^rd_idx;
    assign rd_dist     = '0;
`endif

endmodule

// File: tb/tb_sr04_scan_scheduler.sv
// tb_sr04_scan_scheduler: directed bench for sr04_scan_scheduler with
// NUM_SENSORS=3, PERIOD_US=100, TIMEOUT_US=50 and a tick every 4 clocks.
// A small controller model answers meas_start after a per-sensor tick count.
`timescale 1ns/1ps
module tb_sr04_scan_scheduler;

    localparam int NS    = 3;
    localparam int SEL_W = 2;
    localparam int DW    = 12;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             tick_1MHz;
    logic             enable;
    logic             single;
    logic             meas_done;
    logic [DW-1:0]    meas_dist;
    logic             meas_start;
    logic             meas_abort;
    logic [SEL_W-1:0] sensor_sel;
    logic             busy;
    logic             result_valid;
    logic [SEL_W-1:0] result_idx;
    logic [DW-1:0]    result_dist;
    logic             result_timeout;
    logic [SEL_W-1:0] rd_idx;
    logic [DW-1:0]    rd_dist;

    int testsRun    = 0;
    int testsFailed = 0;

    int            phase           = 0;
    int            ticksSinceStart = 0;
    logic          pendingDone     = 1'b0;
    int            curSel          = 0;
    int            respondAt  [NS];
    logic [DW-1:0] distTable  [NS];

    int            startCount = 0;
    int            startSelLog      [16];
    int            startIntervalLog [16];
    int            abortCount = 0;
    int            abortTicks = -1;
    int            abortSel   = -1;
    int            resCount   = 0;
    int            resIdxLog  [16];
    logic [DW-1:0] resDistLog [16];
    logic          resToLog   [16];

    logic [DW-1:0] expRd1;

    sr04_scan_scheduler #(
        .NUM_SENSORS (NS),
        .PERIOD_US   (100),
        .TIMEOUT_US  (50),
        .DIST_W      (DW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tick_1MHz      (tick_1MHz),
        .enable         (enable),
        .single         (single),
        .meas_done      (meas_done),
        .meas_dist      (meas_dist),
        .meas_start     (meas_start),
        .meas_abort     (meas_abort),
        .sensor_sel     (sensor_sel),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_idx     (result_idx),
        .result_dist    (result_dist),
        .result_timeout (result_timeout),
        .rd_idx         (rd_idx),
        .rd_dist        (rd_dist)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Hard stop in case a bounded loop is ever broken
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 5 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // One clock: observe outputs just after the edge, log events, then drive
    // the tick and the controller model for the coming cycle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        meas_done = 1'b0;
        if (meas_start) begin
            if (startCount < 16) begin
                startSelLog[startCount]      = int'(sensor_sel);
                startIntervalLog[startCount] = ticksSinceStart;
            end
            startCount++;
            curSel          = int'(sensor_sel);
            ticksSinceStart = 0;
            pendingDone     = 1'b0;
        end
        if (meas_abort) begin
            abortCount++;
            abortTicks = ticksSinceStart;
            abortSel   = int'(sensor_sel);
        end
        if (result_valid) begin
            if (resCount < 16) begin
                resIdxLog[resCount]  = int'(result_idx);
                resDistLog[resCount] = result_dist;
                resToLog[resCount]   = result_timeout;
            end
            resCount++;
        end
        if (pendingDone) begin
            meas_done   = 1'b1;
            meas_dist   = distTable[curSel];
            pendingDone = 1'b0;
        end
        phase     = (phase + 1) % 4;
        tick_1MHz = (phase == 0);
        if (tick_1MHz && busy && !meas_start) begin
            ticksSinceStart++;
            if (respondAt[curSel] != 0 && ticksSinceStart == respondAt[curSel]) begin
                pendingDone = 1'b1;
            end
        end
    endtask

    // Single comparison with failure accounting
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Run until the scheduler returns to IDLE, bounded by a cycle budget
    task automatic runUntilIdle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    // Run until the given number of start pulses has been seen, bounded
    task automatic runUntilStarts(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (startCount < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(startCount), 32'(target));
    endtask

    initial begin
        reset_n   = 1'b0;
        tick_1MHz = 1'b0;
        enable    = 1'b0;
        single    = 1'b0;
        meas_done = 1'b0;
        meas_dist = '0;
        rd_idx    = '0;
        distTable[0] = 12'd100;
        distTable[1] = 12'd200;
        distTable[2] = 12'd300;
        for (int i = 0; i < NS; i++) respondAt[i] = 20;

        // Test 1: reset state and no activity while idle
        repeat (5) applyStimulus();
        checkOutput("rst_meas_start", 32'(meas_start), 32'd0);
        checkOutput("rst_meas_abort", 32'(meas_abort), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sel", 32'(sensor_sel), 32'd0);
        checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_result_idx", 32'(result_idx), 32'd0);
        checkOutput("rst_result_dist", 32'(result_dist), 32'd0);
        checkOutput("rst_result_timeout", 32'(result_timeout), 32'd0);
        checkOutput("rst_rd_dist", 32'(rd_dist), 32'd0);
        reset_n = 1'b1;
        repeat (1000) applyStimulus();
        checkOutput("idle_no_start", 32'(startCount), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Test 2: single sweep over all three sensors
        single = 1'b1;
        applyStimulus();
        single = 1'b0;
        checkOutput("sweep_first_start", 32'(startCount), 32'd1);
        runUntilIdle(3000, "sweep_reach_idle");
        checkOutput("sweep_start_count", 32'(startCount), 32'd3);
        checkOutput("sweep_sel0", 32'(startSelLog[0]), 32'd0);
        checkOutput("sweep_sel1", 32'(startSelLog[1]), 32'd1);
        checkOutput("sweep_sel2", 32'(startSelLog[2]), 32'd2);
        checkOutput("sweep_interval1", 32'(startIntervalLog[1]), 32'd100);
        checkOutput("sweep_interval2", 32'(startIntervalLog[2]), 32'd100);
        checkOutput("sweep_result_count", 32'(resCount), 32'd3);
        checkOutput("sweep_res0_idx", 32'(resIdxLog[0]), 32'd0);
        checkOutput("sweep_res0_dist", 32'(resDistLog[0]), 32'd100);
        checkOutput("sweep_res1_idx", 32'(resIdxLog[1]), 32'd1);
        checkOutput("sweep_res1_dist", 32'(resDistLog[1]), 32'd200);
        checkOutput("sweep_res2_idx", 32'(resIdxLog[2]), 32'd2);
        checkOutput("sweep_res2_dist", 32'(resDistLog[2]), 32'd300);
        checkOutput("sweep_res2_timeout", 32'(resToLog[2]), 32'd0);
        checkOutput("sweep_end_sel", 32'(sensor_sel), 32'd0);
        checkOutput("sweep_hold_idx", 32'(result_idx), 32'd2);
        checkOutput("sweep_hold_dist", 32'(result_dist), 32'd300);
        checkOutput("sweep_no_abort", 32'(abortCount), 32'd0);
`ifdef SR04_SCAN_BANK_EN
        expRd1 = 12'd200;
`else
        expRd1 = 12'd0;
`endif
        rd_idx = 2'd1;
        #1;
        checkOutput("bank_rd1", 32'(rd_dist), 32'(expRd1));
        rd_idx = 2'd3;
        #1;
        checkOutput("bank_rd3", 32'(rd_dist), 32'd0);
        rd_idx = 2'd0;

        // Tests 3-5: continuous scan, sensor 1 silent, sensor 2 answers exactly
        // at the timeout tick, enable dropped in sensor 2's slot
        respondAt[0] = 20;
        respondAt[1] = 0;
        respondAt[2] = 50;
        enable = 1'b1;
        runUntilStarts(6, 3000, "scan_reach_sensor2");
        applyStimulus();
        enable = 1'b0;
        single = 1'b1;
        applyStimulus();
        single = 1'b0;
        repeat (5) applyStimulus();
        single = 1'b1;
        applyStimulus();
        single = 1'b0;
        runUntilIdle(2000, "scan_reach_idle");
        checkOutput("scan_start_count", 32'(startCount), 32'd6);
        checkOutput("scan_sel3", 32'(startSelLog[3]), 32'd0);
        checkOutput("scan_sel4", 32'(startSelLog[4]), 32'd1);
        checkOutput("scan_sel5", 32'(startSelLog[5]), 32'd2);
        checkOutput("scan_interval_after_timeout", 32'(startIntervalLog[5]), 32'd100);
        checkOutput("abort_count", 32'(abortCount), 32'd1);
        checkOutput("abort_ticks", 32'(abortTicks), 32'd50);
        checkOutput("abort_sel", 32'(abortSel), 32'd1);
        checkOutput("scan_result_count", 32'(resCount), 32'd6);
        checkOutput("to_res_idx", 32'(resIdxLog[4]), 32'd1);
        checkOutput("to_res_dist", 32'(resDistLog[4]), 32'hFFF);
        checkOutput("to_res_timeout", 32'(resToLog[4]), 32'd1);
        checkOutput("tie_res_idx", 32'(resIdxLog[5]), 32'd2);
        checkOutput("tie_res_dist", 32'(resDistLog[5]), 32'd300);
        checkOutput("tie_res_timeout", 32'(resToLog[5]), 32'd0);
        checkOutput("drop_end_sel", 32'(sensor_sel), 32'd0);

        // Test 6: asynchronous reset in the middle of a WAIT
        respondAt[0] = 0;
        respondAt[1] = 0;
        respondAt[2] = 0;
        enable = 1'b1;
        runUntilStarts(7, 50, "rst_mid_start");
        enable = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_meas_start", 32'(meas_start), 32'd0);
        checkOutput("rst_mid_meas_abort", 32'(meas_abort), 32'd0);
        checkOutput("rst_mid_result_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_mid_result_idx", 32'(result_idx), 32'd0);
        checkOutput("rst_mid_result_dist", 32'(result_dist), 32'd0);
        checkOutput("rst_mid_result_timeout", 32'(result_timeout), 32'd0);
        rd_idx = 2'd2;
        #1;
        checkOutput("rst_mid_rd_dist", 32'(rd_dist), 32'd0);
        repeat (3) applyStimulus();
        reset_n = 1'b1;
        repeat (200) applyStimulus();
        checkOutput("post_rst_no_start", 32'(startCount), 32'd7);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_sel", 32'(sensor_sel), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
